// File: rtl/fp16_column_reducer.sv
// Streaming FP16 column-sum engine: registered pairwise addfp16 tree per column,
// then left-to-right accumulation of up to NUM_COLS column sums per result.
module fp16_column_reducer #(
   parameter int DATA_WIDTH = 16,
   parameter int MAT_HEIGHT = 4,
   parameter int NUM_COLS   = 2
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               valid_in,
   output logic                               ready_in,
   input  logic [DATA_WIDTH-1:0]              column [MAT_HEIGHT],
   input  logic                               last_in,
   output logic                               valid_out,
   input  logic                               ready_out,
   output logic [DATA_WIDTH-1:0]              sum,
   output logic [$clog2(NUM_COLS+1)-1:0]      col_count
);

   localparam int L     = $clog2(MAT_HEIGHT);
   localparam int NODES = MAT_HEIGHT - 1;
   localparam int CW    = $clog2(NUM_COLS + 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(NUM_COLS - 1);

   typedef enum logic {ACCUM, HOLD} state_t;

   // Round-to-nearest-even half-precision add; NaN results are canonical 0x7E00,
   // an exact zero from opposite signs is +0.
   function automatic logic [15:0] addfp16(input logic [15:0] x, input logic [15:0] y);
      logic [15:0] a, b, r;
      logic        x_inf, y_inf, any_nan, sub;
      logic [5:0]  ea, eb, e, d;
      logic [13:0] ma, mb, al, m;
      logic [27:0] wide;
      logic [14:0] s;
      logic [11:0] mr;
      x_inf   = (x[14:10] == 5'h1F) && (x[9:0] == 10'h0);
      y_inf   = (y[14:10] == 5'h1F) && (y[9:0] == 10'h0);
      any_nan = ((x[14:10] == 5'h1F) && (x[9:0] != 10'h0)) ||
                ((y[14:10] == 5'h1F) && (y[9:0] != 10'h0));
      if (x[14:0] >= y[14:0]) begin
         a = x;
         b = y;
      end else begin
         a = y;
         b = x;
      end
      ea   = (a[14:10] == 5'h0) ? 6'd1 : {1'b0, a[14:10]};
      eb   = (b[14:10] == 5'h0) ? 6'd1 : {1'b0, b[14:10]};
      ma   = {a[14:10] != 5'h0, a[9:0], 3'b000};
      mb   = {b[14:10] != 5'h0, b[9:0], 3'b000};
      d    = ea - eb;
      // Alignment keeps guard/round bits and folds everything below into sticky.
      wide = {mb, 14'h0} >> ((d > 6'd15) ? 6'd15 : d);
      al   = wide[27:14] | {13'h0, |wide[13:0]};
      sub  = a[15] ^ b[15];
      s    = sub ? ({1'b0, ma} - {1'b0, al}) : ({1'b0, ma} + {1'b0, al});
      if (s[14]) begin
         m = s[14:1] | {13'h0, s[0]};
         e = ea + 6'd1;
      end else begin
         m = s[13:0];
         e = ea;
      end
      for (int i = 0; i < 13; i++) begin
         if (!m[13] && (e > 6'd1)) begin
            m = m << 1;
            e = e - 6'd1;
         end
      end
      mr = {1'b0, m[13:3]} + {11'h0, m[2] & (m[3] | m[1] | m[0])};
      if (mr[11]) begin
         mr = mr >> 1;
         e  = e + 6'd1;
      end
      if (m == 14'h0)       r = {a[15] & ~sub, 15'h0};
      else if (e >= 6'd31)  r = {a[15], 5'h1F, 10'h0};
      else                  r = {a[15], (mr[10] ? e[4:0] : 5'h0), mr[9:0]};
      if (any_nan || (x_inf && y_inf && (x[15] != y[15]))) r = 16'h7E00;
      else if (x_inf)                                      r = x;
      else if (y_inf)                                      r = y;
      return r;
   endfunction

   logic [DATA_WIDTH-1:0] in_q   [MAT_HEIGHT];
   logic [DATA_WIDTH-1:0] in_d   [MAT_HEIGHT];
   logic [DATA_WIDTH-1:0] node_q [NODES];
   logic [DATA_WIDTH-1:0] node_d [NODES];
   logic [DATA_WIDTH-1:0] node_sum [NODES];
   logic [L:0]            vld_q, vld_d, last_q, last_d;
   state_t                state_q, state_d;
   logic [DATA_WIDTH-1:0] acc_q, acc_d, sum_q, sum_d, acc_add, new_acc;
   logic                  valid_out_q, valid_out_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  stall, accept, tree_vld, tree_last;
   logic [DATA_WIDTH-1:0] tree_sum;

   // Level l nodes live at [MAT_HEIGHT - (MAT_HEIGHT >> l) +: MAT_HEIGHT >> (l+1)].
   for (genvar l = 0; l < L; l++) begin : g_lvl
      for (genvar i = 0; i < (MAT_HEIGHT >> (l + 1)); i++) begin : g_node
         localparam int OUT = MAT_HEIGHT - (MAT_HEIGHT >> l) + i;
         if (l == 0) begin : g_leaf
            assign node_sum[OUT] = addfp16(in_q[2*i], in_q[2*i+1]);
         end else begin : g_inner
            localparam int SRC = MAT_HEIGHT - (MAT_HEIGHT >> (l - 1)) + 2*i;
            assign node_sum[OUT] = addfp16(node_q[SRC], node_q[SRC+1]);
         end
      end
   end

   assign stall     = (state_q == HOLD) && !ready_out;
   assign ready_in  = rst_n && !stall;
   assign accept    = valid_in && ready_in;
   assign tree_vld  = vld_q[L];
   assign tree_last = last_q[L];
   assign tree_sum  = node_q[NODES-1];
   assign acc_add   = addfp16(acc_q, tree_sum);
   assign new_acc   = (cnt_q == '0) ? tree_sum : acc_add;

   always_comb begin
      in_d   = in_q;
      node_d = node_q;
      vld_d  = vld_q;
      last_d = last_q;
      if (!stall) begin
         in_d   = column;
         node_d = node_sum;
         vld_d  = {vld_q[L-1:0], accept};
         last_d = {last_q[L-1:0], accept & last_in};
      end
   end

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      sum_d       = sum_q;
      valid_out_d = valid_out_q;
      cnt_d       = cnt_q;
      if ((state_q == HOLD) && ready_out) begin
         valid_out_d = 1'b0;
         state_d     = ACCUM;
      end
      // A column arriving while the previous result drains opens the next group.
      if (tree_vld && !stall) begin
         acc_d = new_acc;
         if ((cnt_q == LAST_CNT) || tree_last) begin
            sum_d       = new_acc;
            valid_out_d = 1'b1;
            cnt_d       = '0;
            state_d     = HOLD;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         in_q        <= '{default: '0};
         node_q      <= '{default: '0};
         vld_q       <= '0;
         last_q      <= '0;
         state_q     <= ACCUM;
         acc_q       <= '0;
         sum_q       <= '0;
         valid_out_q <= 1'b0;
         cnt_q       <= '0;
      end else begin
         in_q        <= in_d;
         node_q      <= node_d;
         vld_q       <= vld_d;
         last_q      <= last_d;
         state_q     <= state_d;
         acc_q       <= acc_d;
         sum_q       <= sum_d;
         valid_out_q <= valid_out_d;
         cnt_q       <= cnt_d;
      end
   end

   assign valid_out = valid_out_q;
   assign sum       = sum_q;
   assign col_count = cnt_q;

endmodule

// File: doc/fp16_column_reducer.md
# fp16_column_reducer

Pipelined, parametrised FP16 column-sum engine for the decision stage. It accepts one MAT_HEIGHT-element column per handshake and reduces the column through a registered binary `addfp16` tree. It then accumulates NUM_COLS consecutive column sums, or fewer if `last_in` terminates the group, into one FP16 result. The result is presented on a valid/ready output with full backpressure. It generalises the fixed 2x2, FSM-sequenced reduction to arbitrary height, group length and streaming throughput of one column per cycle.

## Interface
- DATA_WIDTH, 16: element width; FP16 only (`addfp16` operands).
- MAT_HEIGHT, 4: elements per column; power of two, >= 2; L = log2(MAT_HEIGHT) tree levels.
- NUM_COLS, 2: columns summed per result; >= 1.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset; sampled on rising clk.
- valid_in  in  1  column valid.
- ready_in  out  1  block can accept a column this cycle.
- column  in  DATA_WIDTH x MAT_HEIGHT  unpacked array, column[0..MAT_HEIGHT-1].
- last_in  in  1  qualifies with valid_in; this column closes the current group early.
- valid_out  out  1  sum valid; held until accepted.
- ready_out  in  1  downstream accepts sum.
- sum  out  DATA_WIDTH  FP16 group total; stable while valid_out && !ready_out.
- col_count  out  $clog2(NUM_COLS+1)  columns accumulated in the open group (debug/status).

## Operation
- Accept = valid_in && ready_in. stall = valid_out && !ready_out. ready_in = rst_n && !stall.
- Tree: level 0 adds column pairs (2i, 2i+1); each level's sums are registered, with a per-level valid bit. The MAT_HEIGHT-1 `addfp16` instances are combinational and are never shared. The `last` flag travels with the valid bits.
- While stall, every tree register, valid bit, accumulator and counter holds. There is no data loss and no duplication.
- Accumulator FSM, states ACCUM and HOLD:
  - ACCUM: when tree output is valid and not stalled:
    - col_count == 0: acc <= tree_sum. The first column is loaded, not added to zero, so -0.0 is preserved.
    - col_count != 0: acc <= addfp16(acc, tree_sum).
    - If col_count == NUM_COLS-1 or the tagged last is set: sum <= the new acc value, valid_out <= 1, col_count <= 0, go to HOLD.
    - Otherwise col_count <= col_count+1.
  - HOLD: valid_out = 1. On ready_out: valid_out <= 0. If a tree output is valid in the same cycle, it is consumed per the ACCUM rules as the first column of the next group. Go to ACCUM, or stay in HOLD if that column also closes its group.
- Result with NUM_COLS=1, or last_in on every column: one sum per column, throughput 1/cycle with ready_out held high.
- Arithmetic: rounding, NaN and Inf handling are exactly those of `addfp16`. Summation order is fixed: pairwise tree, then left-to-right across columns.

## Timing
- Reset (rst_n low at an edge): valid_out=0, sum=0, col_count=0, all tree valid bits 0, FSM=ACCUM. ready_in=0 while rst_n=0, then 1.
- Reset mid-operation: partial groups and in-flight columns are discarded; the first post-reset column starts a new group.
- Latency: for a column accepted at edge k that closes a group, valid_out rises after edge k+L+1, i.e. 3 cycles for MAT_HEIGHT=4.
- Throughput: 1 column/cycle when not stalled. ready_in falls in the same cycle valid_out is high and ready_out is low (combinational).
- Simultaneous accept-out and group close: the new sum is registered on the same edge valid_out is consumed. There is no bubble.
- valid_in while ready_in=0 is ignored; the source holds column and last_in.

## Test plan
- MAT_HEIGHT=4, NUM_COLS=1, column {0x3C00,0x4000,0x4200,0x4400}, ready_out=1 -> valid_out high 3 cycles after accept, sum=0x4900 (10.0) for exactly 1 cycle.
- NUM_COLS=2, columns {1,2,3,4} then {0x3C00 x4} on back-to-back cycles -> a single result, sum=0x4B00 (14.0), col_count sequence 0,1,0.
- NUM_COLS=2, {0x3800 x4} with last_in=1, then {0x3C00 x4} with last_in=1 -> two results, 0x4000 then 0x4400, with no accumulation across the boundary.
- Backpressure: stream 6 columns at NUM_COLS=1 with ready_out low for 4 cycles mid-stream -> ready_in=0 during the stall, sum held stable, and all 6 sums delivered in order with none lost or duplicated.
- Reset mid-group: accept 1 of 2 columns, pulse rst_n low for 1 cycle, then send 2 columns of 0x3C00 -> outputs are 0 during reset, then one result 0x4800 (8.0).
- Signed zero and special values: the single column {0x8000 x4} gives 0x8000, and a column containing 0x7C00 (+Inf) gives 0x7C00.
